bs_frame_feed_ctrl: RTL and testbench

- Sequences bitstream delivery to the nova decoder, one coded frame at a time.
- Accepts 16-bit words from a host stream and writes them into the BitStream RAM starting at address 0.
- Then asserts mem_req_start and holds it until the decoder's pic_num changes (frame done) or a timeout expires. It deasserts for a gap, then loads the next frame.
- Also gates the RAM read data to the decoder to zero while mem_req_start is low.

---
 rtl/bs_feed_pkg.sv | 17 +
 rtl/bs_feed_wr_port.sv | 47 ++++
 rtl/bs_frame_feed_ctrl.sv | 127 ++++++++++++
 tb/tb_bs_frame_feed_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bs_feed_pkg.sv
// Shared types and default widths for the bitstream frame feeder.
package bs_feed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_GAP
  } feed_state_t;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PIC_W   = 6;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/bs_feed_wr_port.sv
// LOAD-phase write side: RAM write pointer, overflow detect and saturating word count.
module bs_feed_wr_port #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic              ovf_hit,
  output logic [ADDR_W:0]   len_next
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr_reg;
  logic              full_reg;
  logic [ADDR_W:0]   cnt_reg;

  // Once the top address has been written, the rest of the frame is drained unwritten.
  assign wen      = accept & ~full_reg;
  assign waddr    = wptr_reg;
  assign ovf_hit  = wen & ~last & (wptr_reg == LAST_ADDR);
  assign len_next = (cnt_reg == DEPTH) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      full_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (clear) begin
      wptr_reg <= '0;
      full_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      cnt_reg <= len_next;
      if (wen) begin
        if (wptr_reg == LAST_ADDR) full_reg <= 1'b1;
        else                       wptr_reg <= wptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_frame_feed_ctrl.sv
// Frame-at-a-time bitstream feeder for the nova decoder: load RAM, hold mem_req_start, gap, repeat.
// Optional RUN timeout enabled by defining BS_FEED_TIMEOUT_EN.
module bs_frame_feed_ctrl
  import bs_feed_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PIC_W       = DEF_PIC_W,
  parameter int TIMEOUT_CYC = 60000,
  parameter int GAP_CYC     = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [DATA_W-1:0]      host_data,
  input  logic                   host_last,
  output logic                   bs_ram_wen,
  output logic [ADDR_W-1:0]      bs_ram_waddr,
  output logic [DATA_W-1:0]      bs_ram_wdata,
  input  logic [DATA_W-1:0]      bs_ram_rdata,
  output logic [DATA_W-1:0]      BitStream_buffer_input,
  output logic                   mem_req_start,
  input  logic [PIC_W-1:0]       pic_num,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [ADDR_W:0]        frame_len,
  output logic                   timeout_err,
  output logic                   ovf_err,
  output logic                   busy
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  feed_state_t            state_reg, state_next;
  logic [PIC_W-1:0]       pic_ref_reg;
  logic [15:0]            gap_cnt_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [ADDR_W:0]        frame_len_reg;
  logic                   ovf_err_reg;
  logic                   accept, pic_chg, run_expire, frame_done;
  logic                   ovf_hit;
  logic [ADDR_W:0]        len_next;

  assign accept     = host_valid & (state_reg == ST_LOAD);
  assign pic_chg    = (pic_num != pic_ref_reg);
  assign frame_done = (state_reg == ST_RUN) & (pic_chg | run_expire);

  bs_feed_wr_port #(.ADDR_W(ADDR_W)) u_wr_port (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (state_reg != ST_LOAD),
    .accept   (accept),
    .last     (host_last),
    .wen      (bs_ram_wen),
    .waddr    (bs_ram_waddr),
    .ovf_hit  (ovf_hit),
    .len_next (len_next)
  );

`ifdef BS_FEED_TIMEOUT_EN
  localparam int RUN_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [RUN_W-1:0] run_cnt_reg;
  logic             timeout_err_reg;

  assign run_expire  = (run_cnt_reg == RUN_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_err_reg;

  // A pic change landing on the final RUN cycle counts as a normal completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      run_cnt_reg <= (state_reg == ST_RUN) ? run_cnt_reg + 1'b1 : '0;
      if ((state_reg == ST_RUN) && run_expire && !pic_chg) timeout_err_reg <= 1'b1;
    end
  end
`else
  assign run_expire  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable) state_next = ST_LOAD;
      ST_LOAD: if (accept && host_last) state_next = ST_ARM;
      ST_ARM:  state_next = ST_RUN;
      ST_RUN:  if (pic_chg || run_expire) state_next = ST_GAP;
      ST_GAP:  if (gap_cnt_reg == GAP_LAST) state_next = enable ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      pic_ref_reg   <= '0;
      gap_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      frame_len_reg <= '0;
      ovf_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= (state_reg == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
      if (state_reg == ST_ARM)  pic_ref_reg   <= pic_num;
      if (frame_done)           frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (accept && host_last)  frame_len_reg <= len_next;
      if (ovf_hit)              ovf_err_reg   <= 1'b1;
    end
  end

  assign host_ready    = (state_reg == ST_LOAD);
  assign mem_req_start = (state_reg == ST_RUN);
  assign busy          = (state_reg != ST_IDLE);
  assign bs_ram_wdata  = host_data;
  assign frame_cnt     = frame_cnt_reg;
  assign frame_len     = frame_len_reg;
  assign ovf_err       = ovf_err_reg;

  // Decoder sees zeros whenever it is not being run on a frame.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_gate
    assign BitStream_buffer_input[gi] = bs_ram_rdata[gi] & mem_req_start;
  end

endmodule

// File: tb/tb_bs_frame_feed_ctrl.sv
// Directed + randomized bench for bs_frame_feed_ctrl against a frame-level reference model.
module tb_bs_frame_feed_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int PIC_W  = 6;
  localparam int TO     = 100;
  localparam int GAP    = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef BS_FEED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [DATA_W-1:0] host_data = '0;
  logic              host_last = 1'b0;
  logic              bs_ram_wen;
  logic [ADDR_W-1:0] bs_ram_waddr;
  logic [DATA_W-1:0] bs_ram_wdata;
  logic [DATA_W-1:0] bs_ram_rdata = '0;
  logic [DATA_W-1:0] buf_in;
  logic              mem_req_start;
  logic [PIC_W-1:0]  pic_num = 6'd3;
  logic [15:0]       frame_cnt;
  logic [ADDR_W:0]   frame_len;
  logic              timeout_err, ovf_err, busy;

  bs_frame_feed_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIC_W(PIC_W),
    .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_last(host_last), .bs_ram_wen(bs_ram_wen), .bs_ram_waddr(bs_ram_waddr),
    .bs_ram_wdata(bs_ram_wdata), .bs_ram_rdata(bs_ram_rdata),
    .BitStream_buffer_input(buf_in), .mem_req_start(mem_req_start),
    .pic_num(pic_num), .frame_cnt(frame_cnt), .frame_len(frame_len),
    .timeout_err(timeout_err), .ovf_err(ovf_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  bit exp_ovf = 1'b0;
  bit exp_to = 1'b0;
  int wa_q[$];
  int wd_q[$];
  int high_cnt = 0;
  int words[$];

  always @(negedge clk) begin
    if (bs_ram_wen) begin
      wa_q.push_back(int'(bs_ram_waddr));
      wd_q.push_back(int'(bs_ram_wdata));
    end
    if (mem_req_start) high_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!host_ready && k < 50) begin
      tick();
      k++;
    end
    chk("load_ready", host_ready, 1);
  endtask

  // Sends n words (sequential 1..n or random, with random idle gaps when random).
  task automatic send(input int n, input bit seq);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(seq ? i + 1 : int'($urandom_range(0, 65535)));
    for (int i = 0; i < n; i++) begin
      if (!seq && $urandom_range(0, 3) == 0) begin
        host_valid = 1'b0;
        tick();
      end
      host_valid = 1'b1;
      host_data  = DATA_W'(words[i]);
      host_last  = (i == n - 1);
      tick();
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic do_frame(input int n, input int r, input bit wrap, input bit drop_en, input bit seq);
    int base, hbase, k, exp_len, exp_hi, got;
    bit timed;
    if (wrap) pic_num = 6'd63;
    wait_ready();
    bs_ram_rdata = DATA_W'($urandom_range(1, 65535));
    #1;
    chk("gate_load", buf_in, 0);
    base = wa_q.size();
    send(n, seq);
    exp_len = (n > DEPTH) ? DEPTH : n;
    if (n > DEPTH) exp_ovf = 1'b1;
    chk("arm_low", mem_req_start, 0);
    chk("frame_len", frame_len, exp_len);
    chk("ovf_err", ovf_err, exp_ovf);
    got = wa_q.size() - base;
    chk("wr_count", got, exp_len);
    for (int i = 0; i < exp_len && i < got; i++) begin
      chk("wr_addr", wa_q[base + i], i);
      chk("wr_data", wd_q[base + i], words[i]);
    end
    if (drop_en) enable = 1'b0;
    tick();
    chk("run_high", mem_req_start, 1);
    hbase = high_cnt;
    bs_ram_rdata = wrap ? 16'hABCD : DATA_W'($urandom_range(0, 65535));
    #1;
    chk("gate_run", buf_in, bs_ram_rdata);
    for (int c = 0; c < r; c++) begin
      tick();
      if (!mem_req_start) break;
    end
    if (mem_req_start) begin
      pic_num = pic_num + 1'b1;
      tick();
    end
    timed  = TO_EN && (r + 1 > TO);
    exp_hi = timed ? TO : r + 1;
    exp_frames++;
    if (timed) exp_to = 1'b1;
    chk("gap_low", mem_req_start, 0);
    chk("frame_cnt", frame_cnt, exp_frames & 32'hFFFF);
    chk("timeout_err", timeout_err, exp_to);
    chk("run_len", high_cnt - hbase, exp_hi);
    k = 0;
    while (busy && !host_ready && k < 50) begin
      tick();
      k++;
    end
    chk("gap_len", k, GAP);
    chk("post_gap_ready", host_ready, enable);
    chk("post_gap_busy", busy, enable);
    $display("frame n=%0d run=%0d len=%0d frames=%0d ovf=%0b to=%0b", n, r, frame_len, frame_cnt, ovf_err, timeout_err);
  endtask

  initial begin
    int base;
    repeat (3) tick();
    chk("rst_ready", host_ready, 0);
    chk("rst_mem", mem_req_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_err", {timeout_err, ovf_err}, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", busy, 0);
    enable = 1'b1;

    do_frame(5, 10, 1'b0, 1'b0, 1'b1);
    repeat (4) do_frame($urandom_range(1, 14), $urandom_range(0, 40), 1'b0, 1'b0, 1'b0);
    do_frame(1, 0, 1'b0, 1'b0, 1'b0);
    do_frame(DEPTH, 3, 1'b0, 1'b0, 1'b0);
    do_frame(20, 3, 1'b0, 1'b0, 1'b0);
    do_frame(6, 8, 1'b1, 1'b0, 1'b0);
    do_frame(3, TO - 1, 1'b0, 1'b0, 1'b0);
    do_frame(3, 150, 1'b0, 1'b0, 1'b0);
    do_frame(4, 6, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("idle_after_drop", {busy, host_ready}, 0);

    enable = 1'b1;
    wait_ready();
    send(3, 1'b0);
    repeat (3) tick();
    chk("pre_rst_run", mem_req_start, 1);
    host_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem", mem_req_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_len", frame_len, 0);
    chk("mid_rst_err", {timeout_err, ovf_err}, 0);
    base = wa_q.size();
    repeat (3) tick();
    chk("mid_rst_nowrite", wa_q.size() - base, 0);
    host_valid = 1'b0;
    exp_frames = 0;
    exp_ovf = 1'b0;
    exp_to = 1'b0;
    reset_n = 1'b1;
    do_frame(4, 5, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
